// File: rtl/audio_in_pkg.sv
// Shared constants and the deserializer state encoding for the audio input path.
// Imported by the FIFO and the top-level deserializer.
package audio_in_pkg;

    localparam int AUD_DATA_WIDTH = 32;
    localparam int AUD_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } aud_state_e;

endpackage

// File: rtl/audio_in_fifo.sv
// First-word-fall-through FIFO holding {left, right} sample pairs.
// Head data reads as zero while empty; clear has priority over push and pop.
module audio_in_fifo
    import audio_in_pkg::*;
#(
    parameter int WIDTH = 2 * AUD_DATA_WIDTH,
    parameter int DEPTH = AUD_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));

    // A pop frees the head slot in the same cycle, so push is accepted even when full.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_in_deserializer.sv
// I2S ADC receiver: synchronizes the codec pins, deserializes left/right words
// and queues completed stereo pairs in a FWFT FIFO with a sticky overflow flag.
module audio_in_deserializer
    import audio_in_pkg::*;
#(
    parameter int DATA_WIDTH = AUD_DATA_WIDTH,
    parameter int FIFO_DEPTH = AUD_FIFO_DEPTH
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  clear_audio_in_memory,
    input  logic                  read_audio_in,
    output logic                  audio_in_available,
    output logic [DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                  overflow
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [1:0]            r_bclk_sync;
    logic [1:0]            r_lrck_sync;
    logic [1:0]            r_dat_sync;
    logic                  r_bclk_prev;
    logic                  r_lrck_last;

    aud_state_e            r_state;
    aud_state_e            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_chan;
    logic                  w_chan_nxt;
    logic [DATA_WIDTH-1:0] r_left;
    logic                  r_left_vld;
    logic                  r_overflow;

    logic                  w_bclk_rise;
    logic                  w_lrck;
    logic                  w_dat;
    logic                  w_lr_edge;
    logic                  w_word_done;
    logic                  w_done_chan;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_bit_vec;
    logic                  w_push;
    logic                  w_empty;
    logic                  w_full;
    logic [2*DATA_WIDTH-1:0] w_rdata;

    assign w_lrck      = r_lrck_sync[1];
    assign w_dat       = r_dat_sync[1];
    assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_prev;
    assign w_lr_edge   = w_bclk_rise & (w_lrck ^ r_lrck_last);
    assign w_bit_vec   = {{(DATA_WIDTH-1){1'b0}}, w_dat};

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_prev <= 1'b0;
            r_lrck_last <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], AUD_BCLK};
            r_lrck_sync <= {r_lrck_sync[0], AUD_ADCLRCK};
            r_dat_sync  <= {r_dat_sync[0], AUD_ADCDAT};
            r_bclk_prev <= r_bclk_sync[1];
            if (w_bclk_rise) r_lrck_last <= w_lrck;
        end
    end

    // The strobe that reveals an LRCK edge carries the I2S delay bit, which is
    // dropped on entry to SKIP; the bit taken while in SKIP is therefore the MSB.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_word_done = 1'b0;
        w_done_chan = r_chan;
        w_word      = r_shift;
        if (w_bclk_rise) begin
            case (r_state)
                IDLE: begin
                    if (w_lr_edge && !w_lrck) begin
                        w_state_nxt = SKIP;
                        w_chan_nxt  = 1'b0;
                    end
                end
                SKIP: begin
                    if (w_lr_edge) begin
                        w_chan_nxt = w_lrck;
                    end else begin
                        w_shift_nxt = {w_dat, {(DATA_WIDTH-1){1'b0}}};
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_lr_edge) begin
                        // Short word: bits already sit MSB-aligned over a zeroed register.
                        w_word_done = 1'b1;
                        w_chan_nxt  = w_lrck;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SKIP;
                    end else begin
                        w_word      = r_shift | (w_bit_vec << (CW'(DATA_WIDTH-1) - r_cnt));
                        w_shift_nxt = w_word;
                        if (r_cnt == CW'(DATA_WIDTH-1)) begin
                            w_word_done = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = HOLD;
                        end else begin
                            w_cnt_nxt   = r_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (w_lr_edge) begin
                        w_chan_nxt  = w_lrck;
                        w_shift_nxt = '0;
                        w_state_nxt = SKIP;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else if (clear_audio_in_memory) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_chan     <= 1'b0;
            r_left     <= '0;
            r_left_vld <= 1'b0;
        end else if (clear_audio_in_memory) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_chan     <= 1'b0;
            r_left     <= '0;
            r_left_vld <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_chan_nxt;
            // A left word is only paired with the right word of the same frame.
            if (w_word_done && !w_done_chan) begin
                r_left     <= w_word;
                r_left_vld <= 1'b1;
            end else if (w_word_done || (w_lr_edge && !w_lrck)) begin
                r_left_vld <= 1'b0;
            end
        end
    end

    assign w_push = w_word_done & w_done_chan & r_left_vld & ~clear_audio_in_memory;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (clear_audio_in_memory) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !(read_audio_in && !w_empty)) begin
            r_overflow <= 1'b1;
        end
    end

    audio_in_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .i_push  (w_push),
        .i_pop   (read_audio_in),
        .i_clear (clear_audio_in_memory),
        .i_wdata ({r_left, w_word}),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign audio_in_available     = ~w_empty;
    assign left_channel_audio_in  = w_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign right_channel_audio_in = w_rdata[DATA_WIDTH-1:0];
    assign overflow               = r_overflow;

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Scoreboard bench for the I2S audio input deserializer: serial frames are
// generated bit by bit, expected pairs queued at send time and popped on read.
module tb_audio_in_deserializer;

    localparam int DW        = 32;
    localparam int DEPTH     = 8;
    localparam int HP        = 8;
    localparam int HALF_BITS = 36;

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0;
    logic          AUD_BCLK = 1'b0;
    logic          AUD_ADCLRCK = 1'b1;
    logic          AUD_ADCDAT = 1'b0;
    logic          clear_audio_in_memory = 1'b0;
    logic          read_audio_in = 1'b0;
    logic          audio_in_available;
    logic [DW-1:0] left_channel_audio_in;
    logic [DW-1:0] right_channel_audio_in;
    logic          overflow;

    logic [2*DW-1:0] q[$];
    logic            m_ovf = 1'b0;
    int              n_vec = 0;
    int              n_err = 0;

    audio_in_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50               (CLOCK_50),
        .resetn                 (resetn),
        .AUD_BCLK               (AUD_BCLK),
        .AUD_ADCLRCK            (AUD_ADCLRCK),
        .AUD_ADCDAT             (AUD_ADCDAT),
        .clear_audio_in_memory  (clear_audio_in_memory),
        .read_audio_in          (read_audio_in),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .overflow               (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: run exceeded cycle budget, required completion");
        $fatal(1);
    end

    // tag: 1 probe availability latency, 2 clear on push, 3 read on push, 4 reset pulse
    task automatic bclk_bit(input logic lr, input logic d, input int tag);
        AUD_BCLK = 1'b0; AUD_ADCLRCK = lr; AUD_ADCDAT = d;
        for (int n = 1; n <= HP; n++) begin
            @(posedge CLOCK_50); #1;
            if (tag == 4 && n == 2) begin
                resetn = 1'b0; #1;
                n_vec++;
                if ({audio_in_available, overflow, left_channel_audio_in, right_channel_audio_in} !== '0) begin
                    n_err++;
                    $display("FAIL reset_midword_outputs: avail=%b ovf=%b l=%h r=%h, required all 0",
                             audio_in_available, overflow, left_channel_audio_in, right_channel_audio_in);
                end
                q.delete(); m_ovf = 1'b0;
            end
            if (tag == 4 && n == 4) resetn = 1'b1;
        end
        AUD_BCLK = 1'b1;
        for (int n = 1; n <= HP; n++) begin
            @(posedge CLOCK_50); #1;
            if (tag == 1 && (n == 2 || n == 3)) begin
                n_vec++;
                if (audio_in_available !== (n == 3)) begin
                    n_err++;
                    $display("FAIL avail_latency: cycle %0d avail=%b, required %b", n, audio_in_available, n == 3);
                end
            end
            if (tag == 2 && n == 2) clear_audio_in_memory = 1'b1;
            if (tag == 2 && n == 3) begin
                clear_audio_in_memory = 1'b0;
                q.delete(); m_ovf = 1'b0;
                n_vec++;
                if (audio_in_available !== 1'b0 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL clear_with_push: avail=%b ovf=%b, required 0 0", audio_in_available, overflow);
                end
            end
            if (tag == 3 && n == 2) begin
                n_vec++;
                if (audio_in_available !== 1'b1 || {left_channel_audio_in, right_channel_audio_in} !== q[0]) begin
                    n_err++;
                    $display("FAIL pushpop_head: avail=%b got %h, required 1 %h", audio_in_available,
                             {left_channel_audio_in, right_channel_audio_in}, q[0]);
                end
                read_audio_in = 1'b1;
            end
            if (tag == 3 && n == 3) begin
                read_audio_in = 1'b0;
                void'(q.pop_front());
            end
        end
    endtask

    task automatic send_half(input logic lr, input logic [DW-1:0] w, input int nb, input int tag);
        bclk_bit(lr, 1'b0, 0);
        for (int i = 0; i < nb; i++) bclk_bit(lr, w[DW-1-i], (i == nb - 1) ? tag : 0);
        for (int i = nb + 1; i < HALF_BITS; i++) bclk_bit(lr, 1'b0, 0);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lbits, input int tag);
        logic [DW-1:0] ones;
        logic [DW-1:0] lexp;
        ones = '1;
        lexp = l & ~(ones >> lbits);
        if (tag != 2) begin
            if (q.size() < DEPTH || tag == 3) q.push_back({lexp, r});
            else m_ovf = 1'b1;
        end
        send_half(1'b0, l, lbits, 0);
        send_half(1'b1, r, DW, tag);
    endtask

    task automatic read_pair(input string nm);
        logic [2*DW-1:0] exp;
        n_vec++;
        if (audio_in_available !== 1'b1 || q.size() == 0) begin
            n_err++;
            $display("FAIL %s_avail: avail=%b queued=%0d, required 1 and nonzero", nm, audio_in_available, q.size());
        end else begin
            exp = q.pop_front();
            n_vec++;
            if ({left_channel_audio_in, right_channel_audio_in} !== exp) begin
                n_err++;
                $display("FAIL %s_data: got %h, required %h", nm, {left_channel_audio_in, right_channel_audio_in}, exp);
            end
        end
        read_audio_in = 1'b1;
        @(posedge CLOCK_50); #1;
        read_audio_in = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        n_vec++;
        if (audio_in_available !== 1'b0 || left_channel_audio_in !== '0 || right_channel_audio_in !== '0
            || overflow !== m_ovf) begin
            n_err++;
            $display("FAIL %s_empty: avail=%b l=%h r=%h ovf=%b, required 0 0 0 %b", nm, audio_in_available,
                     left_channel_audio_in, right_channel_audio_in, overflow, m_ovf);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        n_vec++;
        if ({audio_in_available, overflow, left_channel_audio_in, right_channel_audio_in} !== '0) begin
            n_err++;
            $display("FAIL reset_state: avail=%b ovf=%b l=%h r=%h, required all 0",
                     audio_in_available, overflow, left_channel_audio_in, right_channel_audio_in);
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) bclk_bit(1'b1, 1'b0, 0);
    endtask

    task automatic test_single_frame();
        send_frame(32'h12345678, 32'h9ABCDEF0, DW, 1);
        read_pair("single");
        check_idle("single");
    endtask

    task automatic test_pushpop_full();
        for (int f = 0; f < DEPTH; f++) send_frame($urandom, $urandom, DW, 0);
        send_frame(32'hA5A5_0009, 32'h5A5A_0009, DW, 3);
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL pushpop_ovf: ovf=%b, required 0", overflow);
        end
        for (int f = 0; f < DEPTH; f++) read_pair("pushpop");
        check_idle("pushpop");
    endtask

    task automatic test_overflow();
        for (int f = 1; f <= DEPTH + 1; f++) send_frame(32'h1000_0000 + f, 32'h2000_0000 + f, DW, 0);
        n_vec++;
        if (overflow !== 1'b1 || m_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_flag: ovf=%b, required 1", overflow);
        end
        for (int f = 0; f < DEPTH; f++) read_pair("overflow");
        check_idle("overflow");
    endtask

    task automatic test_clear();
        for (int f = 0; f < 3; f++) send_frame($urandom, $urandom, DW, 0);
        send_frame(32'hC1EA_0001, 32'hC1EA_0002, DW, 2);
        check_idle("clear");
    endtask

    task automatic test_truncate();
        send_frame(32'hFFFF_FFFF, 32'h0F0F_1234, 16, 0);
        read_pair("truncate");
        check_idle("truncate");
    endtask

    task automatic test_reset_midword();
        logic [DW-1:0] l;
        send_frame(32'h0BAD_F00D, 32'h0DEA_DBEE, DW, 0);
        l = 32'hCAFE_BABE;
        bclk_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) bclk_bit(1'b0, l[DW-1-i], 0);
        bclk_bit(1'b0, l[DW-10], 4);
        for (int i = 10; i < DW; i++) bclk_bit(1'b0, l[DW-1-i], 0);
        for (int i = DW + 1; i < HALF_BITS; i++) bclk_bit(1'b0, 1'b0, 0);
        send_half(1'b1, 32'h7777_8888, DW, 0);
        check_idle("reset_trailing");
        send_frame(32'h1357_9BDF, 32'h2468_ACE0, DW, 0);
        read_pair("reset_next");
        check_idle("reset_next");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_pushpop_full();
        test_overflow();
        test_clear();
        test_truncate();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
